// File: rtl/fp_addsub_hs.sv
// ---------------------------------------------------------------------------
// fp_addsub_hs
// Parametrised IEEE-754 binary floating-point adder/subtractor. A multi-cycle
// FSM processes one operation at a time:
//   IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> OUT
// Special operands (NaN, inf, both zero) short-cut from UNPACK to OUT, and an
// exact-zero difference short-cuts from ADD to OUT. Denormals are handled on
// both the input and the output side.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   in_valid   a, b, op_sub and rnd_mode are valid
//   in_ready   idle and not in reset; accept = in_valid & in_ready
//   a, b       operands (W = EXP_W+MAN_W+1 bits)
//   op_sub     0: a+b, 1: a-b (captured at accept)
//   rnd_mode   00 RNE, 01 RTZ, 10 RUP, 11 RDN (captured at accept)
//   out_valid  z and flags are valid; both held until retirement
//   out_ready  consumer ready; retire on out_valid & out_ready
//   z          result
//   flags      {NV, OF, UF, NX}
// ---------------------------------------------------------------------------
module fp_addsub_hs #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op_sub,
    input  logic [1:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   z,
    output logic [3:0]             flags
);

    localparam int W    = EXP_W + MAN_W + 1;
    // Working mantissa: hidden bit, MAN_W fraction bits, guard, round, sticky.
    localparam int MW   = MAN_W + 4;
    localparam int SH_W = $clog2(MAN_W + 4);

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] SH_MAX_E = EXP_W'(MAN_W + 3);
    localparam logic [EXP_W:0]   XEXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_ROUND  = 3'd5,
        ST_OUT    = 3'd6
    } state_t;

    // Leading-zero count of the working mantissa, sized to the exponent path.
    function automatic logic [EXP_W:0] lzc_f(input logic [MW-1:0] v);
        logic [EXP_W:0] n;
        logic           done;
        n    = {(EXP_W+1){1'b0}};
        done = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) begin
                    done = 1'b1;
                end else begin
                    n = n + XEXP_ONE;
                end
            end
        end
        return n;
    endfunction

    state_t state_q, state_d;

    // Captured request
    logic [W-1:0]       a_q, b_q;
    logic               sub_q;
    logic [1:0]         rnd_q;

    // Unpacked operands (b sign already carries the op_sub flip)
    logic               a_sign_q, b_sign_q;
    logic [EXP_W-1:0]   a_exp_q, b_exp_q;
    logic [MAN_W:0]     a_man_q, b_man_q;

    // Datapath between stages
    logic [MW-1:0]      big_man_q, small_man_q;
    logic               eff_sub_q;
    logic               res_sign_q;
    logic [EXP_W:0]     exp_q;
    logic [MW:0]        sum_q;
    logic [MW-1:0]      norm_man_q;
    logic               tiny_q;

    // Registered outputs
    logic [W-1:0]       z_q;
    logic [3:0]         flags_q;
    logic               out_valid_q;

    // Unpack / special-case combinational signals
    logic               a_sign_s, b_sign_s;
    logic [EXP_W-1:0]   a_expf_s, b_expf_s;
    logic [MAN_W-1:0]   a_frac_s, b_frac_s;
    logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic [EXP_W-1:0]   a_exp_s, b_exp_s;
    logic [MAN_W:0]     a_man_s, b_man_s;
    logic               special_s;
    logic [W-1:0]       spec_z_s;
    logic [3:0]         spec_flags_s;

    // Align combinational signals
    logic               a_big_s;
    logic               hi_sign_s;
    logic [EXP_W-1:0]   hi_exp_s, lo_exp_s, exp_diff_s;
    logic [MAN_W:0]     hi_man_s, lo_man_s;
    logic [SH_W-1:0]    sh_s;
    logic [MW-1:0]      lo_ext_s, lo_mask_s, lo_shift_s, lo_al_s;

    // Add / normalise / round combinational signals
    logic [MW:0]        sum_s;
    logic               zero_diff_s;
    logic [EXP_W:0]     lz_s, lim_s, shamt_s, norm_exp_s;
    logic [MW-1:0]      norm_man_s;
    logic               inexact_s, inc_s;
    logic [MAN_W+1:0]   mant_r_s;
    logic [MAN_W:0]     fman_s;
    logic [EXP_W:0]     fexp_s;
    logic [W-1:0]       round_z_s;
    logic [3:0]         round_flags_s;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign flags     = flags_q;

    // Field extraction and special-operand detection for the UNPACK stage.
    always_comb begin
        a_sign_s = a_q[W-1];
        a_expf_s = a_q[W-2:MAN_W];
        a_frac_s = a_q[MAN_W-1:0];
        b_sign_s = b_q[W-1] ^ sub_q;
        b_expf_s = b_q[W-2:MAN_W];
        b_frac_s = b_q[MAN_W-1:0];

        a_nan_s  = (a_expf_s == EXP_ONES) && (a_frac_s != {MAN_W{1'b0}});
        b_nan_s  = (b_expf_s == EXP_ONES) && (b_frac_s != {MAN_W{1'b0}});
        a_inf_s  = (a_expf_s == EXP_ONES) && (a_frac_s == {MAN_W{1'b0}});
        b_inf_s  = (b_expf_s == EXP_ONES) && (b_frac_s == {MAN_W{1'b0}});
        a_zero_s = (a_expf_s == EXP_ZERO) && (a_frac_s == {MAN_W{1'b0}});
        b_zero_s = (b_expf_s == EXP_ZERO) && (b_frac_s == {MAN_W{1'b0}});

        // Denormals use exponent 1 with a zero hidden bit.
        a_exp_s  = (a_expf_s == EXP_ZERO) ? EXP_ONE : a_expf_s;
        b_exp_s  = (b_expf_s == EXP_ZERO) ? EXP_ONE : b_expf_s;
        a_man_s  = {(a_expf_s != EXP_ZERO), a_frac_s};
        b_man_s  = {(b_expf_s != EXP_ZERO), b_frac_s};

        special_s    = 1'b1;
        spec_z_s     = {W{1'b0}};
        spec_flags_s = 4'b0000;
        if (a_nan_s || b_nan_s) begin
            spec_z_s     = QNAN;
            spec_flags_s = 4'b1000;
        end else if (a_inf_s && b_inf_s && (a_sign_s != b_sign_s)) begin
            spec_z_s     = QNAN;
            spec_flags_s = 4'b1000;
        end else if (a_inf_s) begin
            spec_z_s = {a_sign_s, a_q[W-2:0]};
        end else if (b_inf_s) begin
            spec_z_s = {b_sign_s, b_q[W-2:0]};
        end else if (a_zero_s && b_zero_s) begin
            if (a_sign_s == b_sign_s) begin
                spec_z_s = {a_sign_s, {(W-1){1'b0}}};
            end else begin
                spec_z_s = {(rnd_q == RM_RDN), {(W-1){1'b0}}};
            end
        end else begin
            special_s = 1'b0;
        end
    end

    // Order operands by magnitude and right-shift the smaller one with sticky.
    always_comb begin
        a_big_s = {a_exp_q, a_man_q} >= {b_exp_q, b_man_q};
        if (a_big_s) begin
            hi_sign_s = a_sign_q;
            hi_exp_s  = a_exp_q;
            hi_man_s  = a_man_q;
            lo_exp_s  = b_exp_q;
            lo_man_s  = b_man_q;
        end else begin
            hi_sign_s = b_sign_q;
            hi_exp_s  = b_exp_q;
            hi_man_s  = b_man_q;
            lo_exp_s  = a_exp_q;
            lo_man_s  = a_man_q;
        end
        exp_diff_s = hi_exp_s - lo_exp_s;
        // Beyond MAN_W+3 every bit lands in sticky anyway.
        if (exp_diff_s > SH_MAX_E) begin
            sh_s = SH_MAX_E[SH_W-1:0];
        end else begin
            sh_s = exp_diff_s[SH_W-1:0];
        end
        lo_ext_s   = {lo_man_s, 3'b000};
        lo_mask_s  = ~({MW{1'b1}} << sh_s);
        lo_shift_s = lo_ext_s >> sh_s;
        lo_al_s    = {lo_shift_s[MW-1:1], lo_shift_s[0] | (|(lo_ext_s & lo_mask_s))};
    end

    // Magnitude add or subtract; the larger magnitude is always the minuend.
    always_comb begin
        if (eff_sub_q) begin
            sum_s = {1'b0, big_man_q} - {1'b0, small_man_q};
        end else begin
            sum_s = {1'b0, big_man_q} + {1'b0, small_man_q};
        end
        zero_diff_s = (sum_s == {(MW+1){1'b0}});
    end

    // Normalise: fold a carry-out back down, or shift left but never below exponent 1.
    always_comb begin
        lz_s       = lzc_f(sum_q[MW-1:0]);
        lim_s      = exp_q - XEXP_ONE;
        shamt_s    = {(EXP_W+1){1'b0}};
        norm_man_s = sum_q[MW-1:0];
        norm_exp_s = exp_q;
        if (sum_q[MW]) begin
            norm_man_s = {sum_q[MW:2], sum_q[1] | sum_q[0]};
            norm_exp_s = exp_q + XEXP_ONE;
        end else begin
            shamt_s    = (lz_s < lim_s) ? lz_s : lim_s;
            norm_man_s = sum_q[MW-1:0] << shamt_s;
            norm_exp_s = exp_q - shamt_s;
        end
    end

    // Round to the selected mode, renormalise on carry and apply overflow rules.
    always_comb begin
        inexact_s = norm_man_q[2] | norm_man_q[1] | norm_man_q[0];
        case (rnd_q)
            RM_RNE:  inc_s = norm_man_q[2] & (norm_man_q[1] | norm_man_q[0] | norm_man_q[3]);
            RM_RTZ:  inc_s = 1'b0;
            RM_RUP:  inc_s = ~res_sign_q & inexact_s;
            RM_RDN:  inc_s = res_sign_q & inexact_s;
            default: inc_s = 1'b0;
        endcase
        mant_r_s = {1'b0, norm_man_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
        if (mant_r_s[MAN_W+1]) begin
            fman_s = mant_r_s[MAN_W+1:1];
            fexp_s = exp_q + XEXP_ONE;
        end else begin
            fman_s = mant_r_s[MAN_W:0];
            fexp_s = exp_q;
        end

        round_z_s     = {res_sign_q, (fman_s[MAN_W] ? fexp_s[EXP_W-1:0] : EXP_ZERO),
                         fman_s[MAN_W-1:0]};
        round_flags_s = {1'b0, 1'b0, tiny_q & inexact_s, inexact_s};
        if (fexp_s >= {1'b0, EXP_ONES}) begin
            round_flags_s = 4'b0101;
            case (rnd_q)
                RM_RNE:  round_z_s = {res_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                RM_RTZ:  round_z_s = {res_sign_q, EXP_ONES - EXP_ONE, {MAN_W{1'b1}}};
                RM_RUP:  round_z_s = res_sign_q ? {1'b1, EXP_ONES - EXP_ONE, {MAN_W{1'b1}}}
                                                : {1'b0, EXP_ONES, {MAN_W{1'b0}}};
                RM_RDN:  round_z_s = res_sign_q ? {1'b1, EXP_ONES, {MAN_W{1'b0}}}
                                                : {1'b0, EXP_ONES - EXP_ONE, {MAN_W{1'b1}}};
                default: round_z_s = {res_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            endcase
        end else begin
            round_flags_s = {1'b0, 1'b0, tiny_q & inexact_s, inexact_s};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_UNPACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNPACK: begin
                if (special_s) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: state_d = ST_ADD;
            ST_ADD: begin
                if (zero_diff_s) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM:  state_d = ST_ROUND;
            ST_ROUND: state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output registers, advanced one stage per FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            sub_q       <= 1'b0;
            rnd_q       <= 2'b00;
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            a_exp_q     <= EXP_ZERO;
            b_exp_q     <= EXP_ZERO;
            a_man_q     <= {(MAN_W+1){1'b0}};
            b_man_q     <= {(MAN_W+1){1'b0}};
            big_man_q   <= {MW{1'b0}};
            small_man_q <= {MW{1'b0}};
            eff_sub_q   <= 1'b0;
            res_sign_q  <= 1'b0;
            exp_q       <= {(EXP_W+1){1'b0}};
            sum_q       <= {(MW+1){1'b0}};
            norm_man_q  <= {MW{1'b0}};
            tiny_q      <= 1'b0;
            z_q         <= {W{1'b0}};
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= op_sub;
                        rnd_q <= rnd_mode;
                    end
                end
                ST_UNPACK: begin
                    if (special_s) begin
                        z_q         <= spec_z_s;
                        flags_q     <= spec_flags_s;
                        out_valid_q <= 1'b1;
                    end else begin
                        a_sign_q <= a_sign_s;
                        b_sign_q <= b_sign_s;
                        a_exp_q  <= a_exp_s;
                        b_exp_q  <= b_exp_s;
                        a_man_q  <= a_man_s;
                        b_man_q  <= b_man_s;
                    end
                end
                ST_ALIGN: begin
                    big_man_q   <= {hi_man_s, 3'b000};
                    small_man_q <= lo_al_s;
                    eff_sub_q   <= a_sign_q ^ b_sign_q;
                    res_sign_q  <= hi_sign_s;
                    exp_q       <= {1'b0, hi_exp_s};
                end
                ST_ADD: begin
                    sum_q <= sum_s;
                    if (zero_diff_s) begin
                        z_q         <= {(rnd_q == RM_RDN), {(W-1){1'b0}}};
                        flags_q     <= 4'b0000;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_NORM: begin
                    norm_man_q <= norm_man_s;
                    exp_q      <= norm_exp_s;
                    tiny_q     <= ~norm_man_s[MW-1];
                end
                ST_ROUND: begin
                    z_q         <= round_z_s;
                    flags_q     <= round_flags_s;
                    out_valid_q <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_hs.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_hs
// Self-checking bench for fp_addsub_hs (single precision). Directed vectors
// plus randomized operands compared against an exact-integer reference model:
// each operand is expanded to a wide integer in units of the smallest
// denormal, summed exactly, and rounded by inspecting the discarded remainder.
// ---------------------------------------------------------------------------
module tb_fp_addsub_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        op_sub;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [3:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_addsub_hs dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .flags     (flags)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact reference: value = significand * 2^(max(expfield,1)-1) ulps of 2^-149.
    task automatic ref_addsub(input logic [31:0] ra, input logic [31:0] rb, input logic rs,
                              input logic [1:0] rm, output logic [31:0] ez,
                              output logic [3:0] ef, output int elat);
        logic        sa, sb, s, inexact, tiny, inc;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic [299:0] va, vb, mag, kept, rem, half, mask, one;
        int p, e;
        one = {299'd0, 1'b1};
        sa = ra[31]; sb = rb[31] ^ rs;
        ea = ra[30:23]; eb = rb[30:23];
        fa = ra[22:0];  fb = rb[22:0];
        ez = 32'd0; ef = 4'd0; elat = 5;
        if ((ea == 8'hFF && fa != 23'd0) || (eb == 8'hFF && fb != 23'd0)) begin
            ez = 32'h7FC00000; ef = 4'b1000; elat = 1;
        end else if (ea == 8'hFF && eb == 8'hFF && sa != sb) begin
            ez = 32'h7FC00000; ef = 4'b1000; elat = 1;
        end else if (ea == 8'hFF) begin
            ez = {sa, 8'hFF, 23'd0}; elat = 1;
        end else if (eb == 8'hFF) begin
            ez = {sb, 8'hFF, 23'd0}; elat = 1;
        end else if (ra[30:0] == 31'd0 && rb[30:0] == 31'd0) begin
            ez = {(sa == sb) ? sa : (rm == 2'b11), 31'd0}; elat = 1;
        end else begin
            va = {276'd0, (ea != 8'd0), fa} << ((ea == 8'd0) ? 0 : int'(ea) - 1);
            vb = {276'd0, (eb != 8'd0), fb} << ((eb == 8'd0) ? 0 : int'(eb) - 1);
            if (sa == sb) begin mag = va + vb; s = sa; end
            else if (va > vb) begin mag = va - vb; s = sa; end
            else begin mag = vb - va; s = sb; end
            if (mag == 300'd0) begin
                ez = {(rm == 2'b11), 31'd0}; elat = 3;
            end else begin
                p = 0;
                for (int i = 0; i < 300; i++) if (mag[i]) p = i;
                e       = (p <= 23) ? 1 : p - 22;
                mask    = (one << (e - 1)) - one;
                kept    = mag >> (e - 1);
                rem     = mag & mask;
                half    = (e > 1) ? (one << (e - 2)) : 300'd0;
                inexact = (rem != 300'd0);
                tiny    = (p < 23);
                case (rm)
                    2'b00:   inc = (rem > half) || (inexact && rem == half && kept[0]);
                    2'b10:   inc = !s && inexact;
                    2'b11:   inc = s && inexact;
                    default: inc = 1'b0;
                endcase
                kept = kept + {299'd0, inc};
                if (kept == (one << 24)) begin kept = one << 23; e = e + 1; end
                if (e >= 255) begin
                    ef = 4'b0101;
                    if (rm == 2'b01 || (rm == 2'b10 && s) || (rm == 2'b11 && !s))
                        ez = {s, 8'hFE, 23'h7FFFFF};
                    else
                        ez = {s, 8'hFF, 23'd0};
                end else begin
                    ez = {s, kept[23] ? 8'(e) : 8'd0, kept[22:0]};
                    ef = {2'b00, tiny && inexact, inexact};
                end
            end
        end
    endtask

    // One transaction: accept, measure latency, check result, optional back-pressure, retire.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic ts, input logic [1:0] tr, input int hold,
                          input logic [31:0] ez, input logic [3:0] ef, input int elat);
        int guard;
        int lat;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (in_ready !== 1'b1) check_eq({tag, "_in_ready_wait"}, {31'd0, in_ready}, 32'd1);
        a = ta; b = tbv; op_sub = ts; rnd_mode = tr; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom;
        op_sub = 1'($urandom_range(0, 1)); rnd_mode = 2'($urandom_range(0, 3));
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
        check_eq({tag, "_z"}, z, ez);
        check_eq({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check_eq({tag, "_hold_z"}, z, ez);
            check_eq({tag, "_hold_flags"}, {28'd0, flags}, {28'd0, ef});
            check_eq({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_retire_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_retire_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] gen_op(input logic [31:0] peer);
        logic [31:0] r;
        int e;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: begin
                case ($urandom_range(0, 4))
                    0:       r = {r[31], 31'd0};
                    1:       r = {r[31], 8'hFF, 23'd0};
                    2:       r = {r[31], 8'hFF, r[22:0] | 23'd1};
                    3:       r = {r[31], 8'hFE, 23'h7FFFFF};
                    default: r = {r[31], 8'hFE, r[22:0]};
                endcase
            end
            1: r = {r[31], 8'd0, r[22:0]};
            2, 3: begin
                e = int'(peer[30:23]) + int'($urandom_range(0, 6)) - 3;
                if (e < 0) e = 0;
                if (e > 254) e = 254;
                r = {r[31], 8'(e), r[22:0]};
            end
            4: r = peer ^ {24'd0, r[7:0]};
            default: r = r;
        endcase
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ta, tbv, ez;
        logic [3:0]  ef;
        logic        ts;
        logic [1:0]  tr;
        int          elat, hold;

        rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; op_sub = 1'b0;
        rnd_mode = 2'b00; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_z", z, 32'd0);
        check_eq("rst_flags", {28'd0, flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors with hand-computed results.
        run_op("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 2'b00, 0, 32'h40400000, 4'b0000, 5);
        run_op("sub_eq",    32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 0, 32'h00000000, 4'b0000, 3);
        run_op("sub_eq_rdn",32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 0, 32'h80000000, 4'b0000, 3);
        run_op("inf_ninf",  32'h7F800000, 32'hFF800000, 1'b0, 2'b00, 0, 32'h7FC00000, 4'b1000, 1);
        run_op("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, 2'b00, 0, 32'h7FC00000, 4'b1000, 1);
        run_op("ovf_rne",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 0, 32'h7F800000, 4'b0101, 5);
        run_op("ovf_rtz",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, 0, 32'h7F7FFFFF, 4'b0101, 5);
        run_op("den_add",   32'h00000001, 32'h00000001, 1'b0, 2'b00, 0, 32'h00000002, 4'b0000, 5);
        run_op("den_sub",   32'h00800000, 32'h00000001, 1'b1, 2'b00, 0, 32'h007FFFFF, 4'b0000, 5);
        run_op("rnd_rne",   32'h3F800000, 32'h33800000, 1'b0, 2'b00, 0, 32'h3F800000, 4'b0001, 5);
        run_op("rnd_rup",   32'h3F800000, 32'h33800000, 1'b0, 2'b10, 0, 32'h3F800001, 4'b0001, 5);
        run_op("rnd_rdn",   32'h3F800000, 32'h33800000, 1'b0, 2'b11, 0, 32'h3F800000, 4'b0001, 5);
        run_op("hold10",    32'h3F800000, 32'h40000000, 1'b0, 2'b00, 10, 32'h40400000, 4'b0000, 5);

        // Reset while the operation sits in ALIGN: it must vanish.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; op_sub = 1'b0; rnd_mode = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_z", z, 32'd0);
        check_eq("abort_flags", {28'd0, flags}, 32'd0);
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("abort_no_result", {31'd0, out_valid}, 32'd0);
        end
        check_eq("abort_idle_ready", {31'd0, in_ready}, 32'd1);

        // Randomized operands against the exact reference model.
        for (int n = 0; n < 400; n++) begin
            ta   = gen_op($urandom);
            tbv  = gen_op(ta);
            ts   = 1'($urandom_range(0, 1));
            tr   = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            ref_addsub(ta, tbv, ts, tr, ez, ef, elat);
            run_op($sformatf("rnd%0d_%h_%h_%0d_%0d", n, ta, tbv, ts, tr),
                   ta, tbv, ts, tr, hold, ez, ef, elat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
